// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 device-to-host receiver.
package ps2_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PARITY,
    STOP
  } ps2_state_t;

  localparam int unsigned PS2_DATA_BITS  = 8;
  localparam int unsigned PS2_FRAME_BITS = 11;

  // Odd parity holds when the data bits plus the parity bit contain an odd number of ones.
  function automatic logic odd_parity_ok(input logic [PS2_DATA_BITS-1:0] d, input logic p);
    return ^{d, p};
  endfunction

endpackage

// File: rtl/byte_fifo.sv
// Synchronous show-ahead FIFO; pointers carry one extra wrap bit to tell full from empty.
module byte_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW:0]      wr_q, wr_d, rd_q, rd_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push, do_pop;

  assign empty_o = (wr_q == rd_q);
  assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);

  // A pop frees a slot in the same cycle, so a push while full still lands.
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  assign rdata_o = empty_o ? '0 : mem_q[rd_q[AW-1:0]];

  always_comb begin
    wr_d = do_push ? wr_q + 1'b1 : wr_q;
    rd_d = do_pop  ? rd_q + 1'b1 : rd_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q[AW-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/ps2_receiver.sv
// PS/2 device-to-host receiver: pin conditioning, frame FSM with timeout, byte FIFO.
import ps2_pkg::*;

module ps2_receiver #(
  parameter int unsigned FILTER_LEN     = 4,
  parameter int unsigned TIMEOUT_CYCLES = 20000,
  parameter int unsigned FIFO_DEPTH     = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2Clk,
  input  logic       ps2Data,
  output logic [7:0] keyData,
  output logic       keyValid,
  input  logic       keyReady,
  output logic       parityErr,
  output logic       frameErr,
  output logic       overflow
);

  localparam int unsigned FW = $clog2(FILTER_LEN + 1);
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [1:0]               clk_sync_q, dat_sync_q;
  logic                     clk_s, dat_s;
  logic                     filt_q, filt_d;
  logic [FW-1:0]            fcnt_q, fcnt_d;
  logic                     fall;
  logic [TW-1:0]            tmo_q, tmo_d;
  logic                     timeout;
  ps2_state_t               state_q, state_d;
  logic [2:0]               bitcnt_q, bitcnt_d;
  logic [PS2_DATA_BITS-1:0] shift_q, shift_d;
  logic                     par_q, par_d;
  logic                     push_q, push_d;
  logic                     perr_q, perr_d;
  logic                     ferr_q, ferr_d;
  logic                     fifo_full, fifo_empty, pop;

  assign clk_s = clk_sync_q[1];
  assign dat_s = dat_sync_q[1];

  // Filter only commits a new level after FILTER_LEN consecutive differing samples.
  always_comb begin
    filt_d = filt_q;
    fcnt_d = '0;
    if (clk_s != filt_q) begin
      if (fcnt_q == FW'(FILTER_LEN - 1)) filt_d = clk_s;
      else                               fcnt_d = fcnt_q + 1'b1;
    end
  end

  assign fall    = filt_q && !filt_d;
  assign tmo_d   = (state_q == IDLE || fall) ? '0 : tmo_q + 1'b1;
  assign timeout = (state_q != IDLE) && !fall && (tmo_q == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      clk_sync_q <= '1;
      dat_sync_q <= '1;
      filt_q     <= 1'b1;
      fcnt_q     <= '0;
      tmo_q      <= '0;
      state_q    <= IDLE;
    end else begin
      clk_sync_q <= {clk_sync_q[0], ps2Clk};
      dat_sync_q <= {dat_sync_q[0], ps2Data};
      filt_q     <= filt_d;
      fcnt_q     <= fcnt_d;
      tmo_q      <= tmo_d;
      state_q    <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (timeout) begin
      state_d = IDLE;
    end else if (fall) begin
      case (state_q)
        IDLE:    if (!dat_s) state_d = DATA;
        DATA:    if (bitcnt_q == 3'(PS2_DATA_BITS - 1)) state_d = PARITY;
        PARITY:  state_d = STOP;
        STOP:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    shift_d  = shift_q;
    bitcnt_d = bitcnt_q;
    par_d    = par_q;
    push_d   = 1'b0;
    perr_d   = 1'b0;
    ferr_d   = 1'b0;
    if (timeout) begin
      ferr_d  = 1'b1;
      shift_d = '0;
    end else if (fall) begin
      case (state_q)
        IDLE:   bitcnt_d = '0;
        DATA: begin
          shift_d  = {dat_s, shift_q[PS2_DATA_BITS-1:1]};
          bitcnt_d = bitcnt_q + 1'b1;
        end
        PARITY: par_d = dat_s;
        STOP: begin
          if (!dat_s)                              ferr_d = 1'b1;
          else if (!odd_parity_ok(shift_q, par_q)) perr_d = 1'b1;
          else                                     push_d = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bitcnt_q <= '0;
      shift_q  <= '0;
      par_q    <= 1'b0;
      push_q   <= 1'b0;
      perr_q   <= 1'b0;
      ferr_q   <= 1'b0;
    end else begin
      bitcnt_q <= bitcnt_d;
      shift_q  <= shift_d;
      par_q    <= par_d;
      push_q   <= push_d;
      perr_q   <= perr_d;
      ferr_q   <= ferr_d;
    end
  end

  // shift_q holds the committed byte until the next frame starts shifting, so it feeds the FIFO directly.
  byte_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (PS2_DATA_BITS)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst),
    .push_i  (push_q),
    .wdata_i (shift_q),
    .pop_i   (pop),
    .rdata_o (keyData),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign keyValid  = !fifo_empty;
  assign pop       = keyValid && keyReady;
  assign parityErr = perr_q;
  assign frameErr  = ferr_q;
  assign overflow  = push_q && fifo_full && !pop;

endmodule

// File: tb/tb_ps2_receiver.sv
// Self-checking bench for ps2_receiver: scenario tasks plus a queue-based reference model.
`timescale 1ns/1ps

module tb_ps2_receiver;

  localparam int H     = 25;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       ps2Clk = 1'b1;
  logic       ps2Data = 1'b1;
  logic       keyReady = 1'b0;
  logic [7:0] keyData;
  logic       keyValid, parityErr, frameErr, overflow;

  int tests_run = 0;
  int fails = 0;

  int unsigned cyc = 0;
  int unsigned last_fall_cyc = 0;

  logic [7:0] got_q[$];
  int perr_cnt = 0, ferr_cnt = 0, ovf_cnt = 0, valid_hi = 0;
  int unsigned valid_rise_cyc = 0;
  logic prev_valid = 1'b0;

  ps2_receiver #(
    .FILTER_LEN     (4),
    .TIMEOUT_CYCLES (20000),
    .FIFO_DEPTH     (DEPTH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .ps2Clk    (ps2Clk),
    .ps2Data   (ps2Data),
    .keyData   (keyData),
    .keyValid  (keyValid),
    .keyReady  (keyReady),
    .parityErr (parityErr),
    .frameErr  (frameErr),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (keyValid && keyReady) got_q.push_back(keyData);
    if (parityErr) perr_cnt++;
    if (frameErr)  ferr_cnt++;
    if (overflow)  ovf_cnt++;
    if (keyValid)  valid_hi++;
    if (keyValid && !prev_valid) valid_rise_cyc = cyc;
    prev_valid = keyValid;
  end

  initial begin
    #950000;
    $display("FAIL watchdog: time limit reached, tests_run=%0d", tests_run);
    $fatal(1, "watchdog");
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Device drives data while the clock is high; host samples on the falling edge.
  task automatic send_frame(input logic [7:0] d, input logic par_flip, input logic stop_b,
                            input int glitch_bit, input int n_falls);
    logic [10:0] fr;
    fr = {stop_b, (~^d) ^ par_flip, d, 1'b0};
    for (int i = 0; i < n_falls; i++) begin
      ps2Data = fr[i];
      wait_cycles(H);
      if (i == glitch_bit) begin
        ps2Clk = 1'b0;
        wait_cycles(2);
        ps2Clk = 1'b1;
        wait_cycles(H);
      end
      ps2Clk = 1'b0;
      last_fall_cyc = cyc;
      wait_cycles(H);
      ps2Clk = 1'b1;
    end
    ps2Data = 1'b1;
    wait_cycles(2 * H);
  endtask

  task automatic test_reset;
    wait_cycles(3);
    @(negedge clk);
    tests_run++;
    if (keyValid !== 1'b0 || keyData !== 8'h00) begin
      fails++;
      $display("FAIL reset_data: keyValid=%b keyData=%h, want 0/00", keyValid, keyData);
    end
    tests_run++;
    if ({parityErr, frameErr, overflow} !== 3'b000) begin
      fails++;
      $display("FAIL reset_err: errs=%b, want 000", {parityErr, frameErr, overflow});
    end
    @(posedge clk); #1;
    rst = 1'b1;
    wait_cycles(20);
    tests_run++;
    if (keyValid !== 1'b0 || perr_cnt + ferr_cnt + ovf_cnt != 0) begin
      fails++;
      $display("FAIL reset_release: keyValid=%b pulses=%0d, want 0/0", keyValid,
               perr_cnt + ferr_cnt + ovf_cnt);
    end
  endtask

  task automatic test_single;
    int base = got_q.size();
    int vh0 = valid_hi;
    int e0 = perr_cnt + ferr_cnt + ovf_cnt;
    int lat;
    keyReady = 1'b1;
    send_frame(8'h1C, 1'b0, 1'b1, -1, 11);
    lat = int'(valid_rise_cyc) - int'(last_fall_cyc);
    tests_run++;
    if (got_q.size() != base + 1 || got_q[base] !== 8'h1C) begin
      fails++;
      $display("FAIL single_byte: got %0d bytes first=%h, want 1 byte 1c", got_q.size() - base,
               got_q[base]);
    end
    tests_run++;
    if (valid_hi - vh0 != 1) begin
      fails++;
      $display("FAIL single_valid_width: keyValid high %0d cycles, want 1", valid_hi - vh0);
    end
    tests_run++;
    if (perr_cnt + ferr_cnt + ovf_cnt != e0) begin
      fails++;
      $display("FAIL single_noerr: %0d error pulses, want 0", perr_cnt + ferr_cnt + ovf_cnt - e0);
    end
    tests_run++;
    if (lat < 6 || lat > 10) begin
      fails++;
      $display("FAIL single_latency: %0d cycles pin fall to keyValid, want 6..10", lat);
    end
  endtask

  task automatic test_parity;
    int base = got_q.size();
    int p0 = perr_cnt;
    int f0 = ferr_cnt;
    send_frame(8'h1C, 1'b1, 1'b1, -1, 11);
    tests_run++;
    if (perr_cnt - p0 != 1 || ferr_cnt != f0 || got_q.size() != base) begin
      fails++;
      $display("FAIL parity_drop: perr=%0d ferr=%0d bytes=%0d, want 1/0/0", perr_cnt - p0,
               ferr_cnt - f0, got_q.size() - base);
    end
    send_frame(8'hF0, 1'b0, 1'b1, -1, 11);
    tests_run++;
    if (got_q.size() != base + 1 || got_q[base] !== 8'hF0) begin
      fails++;
      $display("FAIL parity_recover: bytes=%0d first=%h, want 1 byte f0", got_q.size() - base,
               got_q[base]);
    end
  endtask

  task automatic test_stop_err;
    int base = got_q.size();
    int p0 = perr_cnt;
    int f0 = ferr_cnt;
    send_frame(8'h55, 1'b1, 1'b0, -1, 11);
    tests_run++;
    if (ferr_cnt - f0 != 1 || perr_cnt != p0 || got_q.size() != base) begin
      fails++;
      $display("FAIL stop_precedence: ferr=%0d perr=%0d bytes=%0d, want 1/0/0", ferr_cnt - f0,
               perr_cnt - p0, got_q.size() - base);
    end
  endtask

  task automatic test_timeout;
    int base = got_q.size();
    int f0 = ferr_cnt;
    send_frame(8'h3A, 1'b0, 1'b1, -1, 5);
    wait_cycles(19800);
    tests_run++;
    if (ferr_cnt != f0) begin
      fails++;
      $display("FAIL timeout_early: ferr=%0d before 20000 idle cycles, want 0", ferr_cnt - f0);
    end
    wait_cycles(250);
    tests_run++;
    if (ferr_cnt - f0 != 1 || got_q.size() != base) begin
      fails++;
      $display("FAIL timeout_fire: ferr=%0d bytes=%0d, want 1/0", ferr_cnt - f0,
               got_q.size() - base);
    end
    send_frame(8'hF0, 1'b0, 1'b1, -1, 11);
    tests_run++;
    if (got_q.size() != base + 1 || got_q[base] !== 8'hF0) begin
      fails++;
      $display("FAIL timeout_recover: bytes=%0d first=%h, want 1 byte f0", got_q.size() - base,
               got_q[base]);
    end
  endtask

  task automatic test_overflow;
    int o0 = ovf_cnt;
    keyReady = 1'b0;
    for (int v = 1; v <= 5; v++) send_frame(8'(v), 1'b0, 1'b1, -1, 11);
    @(negedge clk);
    tests_run++;
    if (ovf_cnt - o0 != 1 || keyValid !== 1'b1 || keyData !== 8'h01) begin
      fails++;
      $display("FAIL overflow_pulse: ovf=%0d keyValid=%b head=%h, want 1/1/01", ovf_cnt - o0,
               keyValid, keyData);
    end
    @(posedge clk); #1;
    keyReady = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      tests_run++;
      if (keyValid !== 1'b1 || keyData !== 8'(k + 1)) begin
        fails++;
        $display("FAIL overflow_drain%0d: keyValid=%b keyData=%h, want 1/%h", k, keyValid,
                 keyData, 8'(k + 1));
      end
    end
    @(negedge clk);
    tests_run++;
    if (keyValid !== 1'b0) begin
      fails++;
      $display("FAIL overflow_empty: keyValid=%b, want 0", keyValid);
    end
    wait_cycles(2);
  endtask

  task automatic test_reset_midframe;
    int base;
    int f0 = ferr_cnt;
    keyReady = 1'b0;
    send_frame(8'hAA, 1'b0, 1'b1, -1, 11);
    send_frame(8'h1C, 1'b0, 1'b1, -1, 5);
    tests_run++;
    if (keyValid !== 1'b1 || keyData !== 8'hAA) begin
      fails++;
      $display("FAIL midreset_queued: keyValid=%b keyData=%h, want 1/aa", keyValid, keyData);
    end
    #3;
    rst = 1'b0;
    @(negedge clk);
    tests_run++;
    if ({keyValid, keyData, parityErr, frameErr, overflow} !== 12'h000) begin
      fails++;
      $display("FAIL midreset_outputs: keyValid=%b keyData=%h errs=%b, want all 0", keyValid,
               keyData, {parityErr, frameErr, overflow});
    end
    wait_cycles(4);
    rst = 1'b1;
    keyReady = 1'b1;
    wait_cycles(30000 / 1000);
    base = got_q.size();
    tests_run++;
    if (keyValid !== 1'b0) begin
      fails++;
      $display("FAIL midreset_empty: keyValid=%b after release, want 0", keyValid);
    end
    send_frame(8'h1C, 1'b0, 1'b1, -1, 11);
    tests_run++;
    if (got_q.size() != base + 1 || got_q[base] !== 8'h1C || ferr_cnt != f0) begin
      fails++;
      $display("FAIL midreset_recover: bytes=%0d first=%h ferr=%0d, want 1 byte 1c ferr 0",
               got_q.size() - base, got_q[base], ferr_cnt - f0);
    end
  endtask

  task automatic test_glitch;
    int base = got_q.size();
    int e0 = perr_cnt + ferr_cnt;
    keyReady = 1'b1;
    ps2Data = 1'b0;
    wait_cycles(5);
    ps2Clk = 1'b0;
    wait_cycles(2);
    ps2Clk = 1'b1;
    wait_cycles(10);
    ps2Data = 1'b1;
    wait_cycles(20);
    send_frame(8'h5A, 1'b0, 1'b1, 3, 11);
    tests_run++;
    if (got_q.size() != base + 1 || got_q[base] !== 8'h5A || perr_cnt + ferr_cnt != e0) begin
      fails++;
      $display("FAIL glitch_reject: bytes=%0d first=%h errs=%0d, want 1 byte 5a errs 0",
               got_q.size() - base, got_q[base], perr_cnt + ferr_cnt - e0);
    end
  endtask

  // Model: good frames appear in order, bad-parity and bad-stop frames only bump their counter.
  task automatic test_random;
    logic [7:0] exp_q[$];
    int base = got_q.size();
    int p0 = perr_cnt;
    int f0 = ferr_cnt;
    int exp_p = 0, exp_f = 0;
    keyReady = 1'b1;
    for (int n = 0; n < 16; n++) begin
      logic [7:0] d;
      int kind;
      d = 8'($urandom);
      kind = int'($urandom_range(0, 3));
      if (kind == 3) begin
        send_frame(d, 1'($urandom), 1'b0, -1, 11);
        exp_f++;
      end else if (kind == 2) begin
        send_frame(d, 1'b1, 1'b1, -1, 11);
        exp_p++;
      end else begin
        send_frame(d, 1'b0, 1'b1, -1, 11);
        exp_q.push_back(d);
      end
    end
    tests_run++;
    if (got_q.size() - base != exp_q.size() || perr_cnt - p0 != exp_p || ferr_cnt - f0 != exp_f) begin
      fails++;
      $display("FAIL random_counts: bytes=%0d perr=%0d ferr=%0d, want %0d/%0d/%0d",
               got_q.size() - base, perr_cnt - p0, ferr_cnt - f0, exp_q.size(), exp_p, exp_f);
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      tests_run++;
      if (got_q[base + i] !== exp_q[i]) begin
        fails++;
        $display("FAIL random_byte%0d: got %h, want %h", i, got_q[base + i], exp_q[i]);
      end
    end
  endtask

  // Model: with the consumer stalled, the first DEPTH bytes are kept and the rest overflow.
  task automatic test_back_to_back;
    for (int r = 0; r < 3; r++) begin
      logic [7:0] exp_q[$];
      int n = int'($urandom_range(1, 6));
      int base = got_q.size();
      int o0 = ovf_cnt;
      int exp_o = 0;
      keyReady = 1'b0;
      for (int k = 0; k < n; k++) begin
        logic [7:0] d;
        d = 8'($urandom);
        send_frame(d, 1'b0, 1'b1, -1, 11);
        if (exp_q.size() < DEPTH) exp_q.push_back(d);
        else exp_o++;
      end
      keyReady = 1'b1;
      wait_cycles(10);
      tests_run++;
      if (got_q.size() - base != exp_q.size() || ovf_cnt - o0 != exp_o) begin
        fails++;
        $display("FAIL burst%0d_counts: bytes=%0d ovf=%0d, want %0d/%0d", r, got_q.size() - base,
                 ovf_cnt - o0, exp_q.size(), exp_o);
      end
      for (int i = 0; i < exp_q.size(); i++) begin
        tests_run++;
        if (got_q[base + i] !== exp_q[i]) begin
          fails++;
          $display("FAIL burst%0d_byte%0d: got %h, want %h", r, i, got_q[base + i], exp_q[i]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_parity();
    test_stop_err();
    test_timeout();
    test_overflow();
    test_reset_midframe();
    test_glitch();
    test_random();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
